// File: rtl/tff_bank_if.sv
// Command port of tff_bank: valid/ready handshake carrying an opcode and a WIDTH-bit mask/value.
// The master drives the command and the slave (the bank) returns ready.
interface tff_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/tff_bank.sv
// Multi-channel toggle flip-flop bank with masked toggle/load/clear/pulse commands and a
// saturating toggle-event counter. Define TFF_BANK_PARITY_EN to add the registered q_par output.
module tff_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      CNT_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  tff_bank_if.slave        cmd,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
`ifdef TFF_BANK_PARITY_EN
  output logic             q_par,
`endif
  output logic [CNT_W-1:0] tgl_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    OpToggle = 2'b00,
    OpLoad   = 2'b01,
    OpClear  = 2'b10,
    OpPulse  = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    StIdle,
    StPulse
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             cnt_inc;
  op_e              op;

  assign op = op_e'(cmd.cmd_op);

  // Handshake outputs decode the state only, so there is no comb path from the inputs.
  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q == StPulse);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    pulse_mask_d = pulse_mask_q;
    cnt_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op)
            OpToggle: begin
              q_d     = q_q ^ cmd.cmd_data;
              cnt_inc = |cmd.cmd_data;
            end
            OpLoad:  q_d = cmd.cmd_data;
            OpClear: q_d = q_q & ~cmd.cmd_data;
            OpPulse: begin
              q_d          = q_q ^ cmd.cmd_data;
              pulse_mask_d = cmd.cmd_data;
              cnt_inc      = |cmd.cmd_data;
              state_d      = StPulse;
            end
            default: ;
          endcase
        end
      end
      StPulse: begin
        // Restore edge: undo the pulse; not counted as a toggle event.
        q_d     = q_q ^ pulse_mask_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      q_q          <= RST_VAL;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      pulse_mask_q <= pulse_mask_d;
      cnt_q        <= cnt_d;
    end
  end

  assign q       = q_q;
  assign tgl_cnt = cnt_q;

`ifdef TFF_BANK_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= ^RST_VAL;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign q_par = par_q;
`endif

endmodule

// File: tb/tb_tff_bank.sv
// Self-checking bench for tff_bank: a behavioural model checked every negative clock edge,
// plus directed vectors with hand-computed literal expectations.
module tb_tff_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] tgl_cnt;
  logic             busy;
`ifdef TFF_BANK_PARITY_EN
  logic             q_par;
`endif

  int n_checks;
  int n_fail;

  tff_bank_if #(.WIDTH(WIDTH)) cmd_bus ();

  tff_bank #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .RST_VAL(8'h00)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_bus),
    .cnt_clr(cnt_clr),
    .q      (q),
`ifdef TFF_BANK_PARITY_EN
    .q_par  (q_par),
`endif
    .tgl_cnt(tgl_cnt),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, pending pulse tracked as a mask still to be undone.
  int m_q;
  int m_cnt;
  int m_pend;
  bit m_busy;

  always @(negedge rst_n) begin
    m_q    = 0;
    m_cnt  = 0;
    m_pend = 0;
    m_busy = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int d;
      bit counts;
      d      = int'(cmd_bus.cmd_data);
      counts = 0;
      if (m_busy) begin
        m_q    = m_q ^ m_pend;
        m_busy = 0;
      end else if (cmd_bus.cmd_valid) begin
        case (cmd_bus.cmd_op)
          2'd0: begin m_q = m_q ^ d; counts = (d != 0); end
          2'd1: m_q = d;
          2'd2: m_q = m_q & ~d & 255;
          default: begin m_q = m_q ^ d; m_pend = d; m_busy = 1; counts = (d != 0); end
        endcase
      end
      if (cnt_clr) m_cnt = 0;
      else if (counts && m_cnt < 15) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_cnt", 32'(tgl_cnt), 32'(m_cnt));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_ready", 32'(cmd_bus.cmd_ready), 32'(!m_busy));
`ifdef TFF_BANK_PARITY_EN
    chk("model_par", 32'(q_par), 32'(^m_q[7:0]));
    chk("par_vs_q", 32'(q_par), 32'(^q));
`endif
  end

  // Drive one cycle of stimulus, then land 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] d,
                      input logic clr = 1'b0);
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_data  = d;
    cnt_clr           = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    cnt_clr           = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'd0;
    cmd_bus.cmd_data  = 8'h00;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: asynchronous reset mid-cycle after dirtying state
    step(1'b1, 2'd0, 8'h5A);
    chk("pre_reset_q", 32'(q), 32'h5A);
    cmd_bus.cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_cnt", 32'(tgl_cnt), 32'd0);
    chk("reset_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: toggles and zero-mask toggle
    step(1'b1, 2'd0, 8'hA5);
    chk("tgl_a5", 32'(q), 32'hA5);
    step(1'b1, 2'd0, 8'h0F);
    chk("tgl_0f", 32'(q), 32'hAA);
    chk("tgl_cnt2", 32'(tgl_cnt), 32'd2);
    step(1'b1, 2'd0, 8'h00);
    chk("tgl_00_q", 32'(q), 32'hAA);
    chk("tgl_00_cnt", 32'(tgl_cnt), 32'd2);

    // 3: load and clear
    step(1'b1, 2'd1, 8'h3C);
    chk("load_3c", 32'(q), 32'h3C);
    step(1'b1, 2'd2, 8'h0C);
    chk("clear_0c", 32'(q), 32'h30);
    chk("ld_clr_cnt", 32'(tgl_cnt), 32'd2);

    // 4: pulse, held toggle ignored during pulse, then accepted
    step(1'b1, 2'd3, 8'h81);
    chk("pulse_q", 32'(q), 32'hB1);
    chk("pulse_busy", 32'(busy), 32'd1);
    chk("pulse_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    step(1'b1, 2'd0, 8'hFF);
    chk("restore_q", 32'(q), 32'h30);
    chk("restore_busy", 32'(busy), 32'd0);
    step(1'b1, 2'd0, 8'hFF);
    chk("held_tgl_q", 32'(q), 32'hCF);
    chk("pulse_cnt", 32'(tgl_cnt), 32'd4);

    // 5: saturation, then clear wins over a same-cycle increment
    for (int i = 0; i < 17; i++) step(1'b1, 2'd0, 8'h01);
    chk("sat_cnt", 32'(tgl_cnt), 32'd15);
    chk("sat_q", 32'(q), 32'hCE);
    step(1'b1, 2'd0, 8'h01, 1'b1);
    chk("clr_cnt", 32'(tgl_cnt), 32'd0);
    chk("clr_q", 32'(q), 32'hCF);

    // 6: reset during pulse discards the restore toggle
    step(1'b1, 2'd3, 8'h03);
    chk("pulse2_q", 32'(q), 32'hCC);
    chk("pulse2_busy", 32'(busy), 32'd1);
    cmd_bus.cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pulse_q", 32'(q), 32'h00);
    chk("rst_pulse_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 2'd0, 8'h00);
    step(1'b0, 2'd0, 8'h00);
    chk("no_restore_q", 32'(q), 32'h00);
    chk("no_restore_cnt", 32'(tgl_cnt), 32'd0);
    chk("post_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);

    step(1'b1, 2'd0, 8'h11);
    chk("post_rst_tgl", 32'(q), 32'h11);
    step(1'b0, 2'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
